// File: rtl/lwmac_cfg_pkg.sv
// lwmac_cfg_pkg: address map, legal-offset rule and FSM encoding for the lwmac config master.
// Optional feature macro: CFG_WRITE_VERIFY_EN (adds the ST_VRD/ST_VCMP readback states).
package lwmac_cfg_pkg;

  localparam logic [31:0] LWMAC_CFG_BASE  = 32'hFFFFFA40;
  localparam int unsigned LWMAC_CFG_WORDS = 32;

  localparam logic [4:0] LWMAC_CFG_OFF_CTRL    = 5'h00;
  localparam logic [4:0] LWMAC_CFG_OFF_STAT    = 5'h01;
  localparam logic [4:0] LWMAC_CFG_OFF_BANK_LO = 5'h12;
  localparam logic [4:0] LWMAC_CFG_OFF_BANK_HI = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR  = 3'd3,
    ST_RESP = 3'd4
`ifdef CFG_WRITE_VERIFY_EN
    ,
    ST_VRD  = 3'd5,
    ST_VCMP = 3'd6
`endif
  } cfg_state_e;

  // The upper bank ends at the top of the 5-bit index space, so only its floor needs a compare.
  function automatic logic lwmac_cfg_offset_ok(input logic [4:0] off);
    return (off == LWMAC_CFG_OFF_CTRL) || (off == LWMAC_CFG_OFF_STAT) ||
           (off >= LWMAC_CFG_OFF_BANK_LO);
  endfunction

endpackage

// File: rtl/lwmac_cfg_master_if.sv
// lwmac_cfg_master_if: host request/response channel (valid/ready both ways).
// master = host side, slave = the config master block.
interface lwmac_cfg_master_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/lwmac_cfg_addr_chk.sv
// lwmac_cfg_addr_chk: combinational window/offset decode for the config register file.
// Also used by the host bus decoder, so it carries no state.
module lwmac_cfg_addr_chk
  import lwmac_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = LWMAC_CFG_BASE
) (
  input  logic [31:0] addr,
  output logic        legal,
  output logic [4:0]  offset
);

  logic [31:0] off_full;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and fail the range test.
  assign off_full = addr - BASE_ADDR;
  assign offset   = off_full[4:0];
  assign legal    = (off_full < 32'(LWMAC_CFG_WORDS)) && lwmac_cfg_offset_ok(off_full[4:0]);

endmodule

// File: rtl/lwmac_cfg_master.sv
// lwmac_cfg_master: one-outstanding host initiator for the lwmac 32-entry config register file.
// Optional feature macro: CFG_WRITE_VERIFY_EN reads each write back and flags a mismatch.
module lwmac_cfg_master
  import lwmac_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = LWMAC_CFG_BASE,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lwmac_cfg_master_if.slave host,
  output logic              write,
  output logic [31:0]       wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [31:0]       rdAddrA,
  input  logic [DATA_W-1:0] rdDataA
);

  cfg_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              write_q, write_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;

  logic              req_legal;
  logic [4:0]        req_offset;

  lwmac_cfg_addr_chk #(.BASE_ADDR(BASE_ADDR)) u_addr_chk (
    .addr   (host.req_addr),
    .legal  (req_legal),
    .offset (req_offset)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    write_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (host.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (!req_legal) begin
            state_d = ST_ERR;
          end else if (host.req_we) begin
            // Outputs are registered, so the strobe is set here to appear in the WR cycle.
            state_d   = ST_WR;
            write_d   = 1'b1;
            wr_addr_d = req_offset;
            wr_data_d = host.req_wdata;
          end else begin
            state_d   = ST_RD;
            rd_addr_d = req_offset;
          end
        end
      end

      ST_WR: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef CFG_WRITE_VERIFY_EN
        state_d   = ST_VRD;
        rd_addr_d = wr_addr_q;
`else
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
`endif
      end

`ifdef CFG_WRITE_VERIFY_EN
      ST_VRD: begin
        state_d = ST_VCMP;
      end

      ST_VCMP: begin
        rsp_rdata_d = rdDataA;
        rsp_err_d   = (rdDataA != wr_data_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
`endif

      ST_RD: begin
        rsp_rdata_d = rdDataA;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_ERR: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if (host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      write_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      write_q     <= write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_err   = rsp_err_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign write          = write_q;
  assign wrAddr         = {27'd0, wr_addr_q};
  assign wrData         = wr_data_q;
  assign rdAddrA        = {27'd0, rd_addr_q};

endmodule

// File: tb/tb_lwmac_cfg_master.sv
// tb_lwmac_cfg_master: directed plus randomized transactions against a register-file model
// and a transaction-level shadow copy of the expected register contents.
module tb_lwmac_cfg_master;

  localparam logic [31:0] BASE = 32'hFFFFFA40;
`ifdef CFG_WRITE_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr_a, rd_data_a;

  logic [31:0] rf [32];
  logic [31:0] init_rf [32];
  logic [31:0] shadow [32];
  logic        load_rf = 1'b0;
  logic        force_rb = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;
  int write_cnt = 0;
  int acc_cnt = 0;
  int cyc = 0;
  int acc_q[$];
  int txn_id = 0;

  lwmac_cfg_master_if #(.DATA_W(32)) hif ();

  lwmac_cfg_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (hif.slave),
    .write   (wr_en),
    .wrAddr  (wr_addr),
    .wrData  (wr_data),
    .rdAddrA (rd_addr_a),
    .rdDataA (rd_data_a)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, optional forced-zero readback, writes ignored in reset.
  assign rd_data_a = force_rb ? 32'h0 : rf[rd_addr_a[4:0]];

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_rf[i];
    end else if (rst_n && wr_en) begin
      rf[wr_addr[4:0]] <= wr_data;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && wr_en) write_cnt <= write_cnt + 1;
    if (rst_n && hif.req_valid && hif.req_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference address rule: window membership plus the allowed offset set.
  function automatic bit ref_legal(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off > 32'd31) return 1'b0;
    return (off == 32'd0) || (off == 32'd1) || (off >= 32'd18);
  endfunction

  task automatic wait_ready();
    int guard = 0;
    while (hif.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("req_ready_idle", 32'(hif.req_ready), 32'd1);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input bit force_zero);
    bit          legal;
    logic [31:0] off_full;
    logic [4:0]  off;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          lat;
    int          wr0;
    int          acc0;

    legal     = ref_legal(addr);
    off_full  = addr - BASE;
    off       = off_full[4:0];
    exp_err   = 1'b0;
    exp_rdata = 32'h0;
    exp_lat   = 2;
    if (!legal) begin
      exp_err = 1'b1;
    end else if (we) begin
      exp_lat = WR_LAT;
`ifdef CFG_WRITE_VERIFY_EN
      exp_rdata = force_zero ? 32'h0 : wdata;
      exp_err   = (exp_rdata != wdata);
`endif
    end else begin
      exp_rdata = shadow[off];
    end

    wait_ready();
    force_rb       = force_zero;
    hif.rsp_ready  = (hold == 0);
    hif.req_valid  = 1'b1;
    hif.req_we     = we;
    hif.req_addr   = addr;
    hif.req_wdata  = wdata;
    wr0  = write_cnt;
    acc0 = acc_cnt;
    @(posedge clk);
    #1 hif.req_valid = 1'b0;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check_val("write_strobe", 32'(wr_en), 32'(legal && we));
        if (legal && we) begin
          check_val("wr_addr", wr_addr, 32'(off));
          check_val("wr_data", wr_data, wdata);
        end
        if (legal && !we) check_val("rd_addr", rd_addr_a, 32'(off));
      end
    end while (hif.rsp_valid !== 1'b1 && lat < 12);

    check_val("rsp_latency", 32'(lat), 32'(exp_lat));
    check_val("rsp_err", 32'(hif.rsp_err), 32'(exp_err));
    check_val("rsp_rdata", hif.rsp_rdata, exp_rdata);
    check_val("accept_count", 32'(acc_cnt - acc0), 32'd1);

    for (int k = 0; k < hold; k++) begin
      if (k == 0) begin
        hif.req_valid = 1'b1;
        hif.req_we    = 1'b0;
        hif.req_addr  = BASE;
      end
      @(negedge clk);
      check_val("hold_rsp_valid", 32'(hif.rsp_valid), 32'd1);
      check_val("hold_rsp_rdata", hif.rsp_rdata, exp_rdata);
      check_val("hold_rsp_err", 32'(hif.rsp_err), 32'(exp_err));
      check_val("hold_req_ready", 32'(hif.req_ready), 32'd0);
    end
    if (hold > 0) begin
      hif.req_valid = 1'b0;
      check_val("hold_no_accept", 32'(acc_cnt - acc0), 32'd1);
    end

    hif.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rsp_released", 32'(hif.rsp_valid), 32'd0);
    check_val("write_count", 32'(write_cnt - wr0), 32'(legal && we));
    force_rb = 1'b0;
    if (legal && we) shadow[off] = wdata;

    $display("txn %0d we=%0d addr=%08h wdata=%08h hold=%0d err=%0d rdata=%08h lat=%0d",
             txn_id, we, addr, wdata, hold, hif.rsp_err, hif.rsp_rdata, lat);
    txn_id++;
  endtask

  initial begin
    int          sel;
    int          hold;
    int          acc0;
    int          n0;
    int          wr0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          frc;

    rst_n          = 1'b0;
    hif.req_valid  = 1'b0;
    hif.req_we     = 1'b0;
    hif.req_addr   = 32'h0;
    hif.req_wdata  = 32'h0;
    hif.rsp_ready  = 1'b1;

    for (int i = 0; i < 32; i++) begin
      init_rf[i] = $urandom;
      shadow[i]  = init_rf[i];
    end
    init_rf[1] = 32'h12345678;
    shadow[1]  = 32'h12345678;
    load_rf = 1'b1;
    repeat (3) @(negedge clk);
    load_rf = 1'b0;

    check_val("rst_req_ready", 32'(hif.req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(hif.rsp_valid), 32'd0);
    check_val("rst_rsp_err", 32'(hif.rsp_err), 32'd0);
    check_val("rst_rsp_rdata", hif.rsp_rdata, 32'd0);
    check_val("rst_write", 32'(wr_en), 32'd0);
    check_val("rst_wr_addr", wr_addr, 32'd0);
    check_val("rst_wr_data", wr_data, 32'd0);
    check_val("rst_rd_addr", rd_addr_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_req_ready", 32'(hif.req_ready), 32'd1);

    run_txn(1'b1, 32'hFFFFFA52, 32'hDEADBEEF, 0, 1'b0);
    run_txn(1'b0, 32'hFFFFFA41, 32'h0, 0, 1'b0);
    run_txn(1'b1, 32'hFFFFFA45, 32'h11111111, 0, 1'b0);
    run_txn(1'b1, 32'hFFFFFA60, 32'h22222222, 0, 1'b0);
    run_txn(1'b1, 32'h00000000, 32'h33333333, 0, 1'b0);
    run_txn(1'b0, 32'hFFFFFA45, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'hFFFFFA41, 32'h0, 5, 1'b0);
    run_txn(1'b1, 32'hFFFFFA40, 32'hA5A5A5A5, 0, 1'b1);
    run_txn(1'b1, 32'hFFFFFA40, 32'hA5A5A5A5, 0, 1'b0);
    run_txn(1'b0, 32'hFFFFFA40, 32'h0, 0, 1'b0);
    run_txn(1'b0, 32'hFFFFFA3F, 32'h0, 0, 1'b0);

    // Reset asserted during the write-strobe cycle.
    wait_ready();
    wr0 = write_cnt;
    hif.req_valid = 1'b1;
    hif.req_we    = 1'b1;
    hif.req_addr  = 32'hFFFFFA5F;
    hif.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 hif.req_valid = 1'b0;
    @(negedge clk);
    check_val("abort_wr_cycle", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_write", 32'(wr_en), 32'd0);
    check_val("abort_rsp_valid", 32'(hif.rsp_valid), 32'd0);
    check_val("abort_req_ready", 32'(hif.req_ready), 32'd0);
    check_val("abort_wr_addr", wr_addr, 32'd0);
    check_val("abort_wr_data", wr_data, 32'd0);
    check_val("abort_rd_addr", rd_addr_a, 32'd0);
    check_val("abort_rsp_rdata", hif.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_ready_after", 32'(hif.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("abort_no_rsp", 32'(hif.rsp_valid), 32'd0);
    end
    check_val("abort_no_replay", 32'(write_cnt - wr0), 32'd0);
    $display("txn %0d reset-abort write addr=FFFFFA5F", txn_id);
    txn_id++;

    // Back-to-back reads with req_valid and rsp_ready held high.
    wait_ready();
    acc0 = acc_cnt;
    n0   = acc_q.size();
    hif.rsp_ready = 1'b1;
    hif.req_valid = 1'b1;
    hif.req_we    = 1'b0;
    hif.req_addr  = 32'hFFFFFA41;
    repeat (10) @(posedge clk);
    #1 hif.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val("b2b_accepts", 32'(acc_cnt - acc0), 32'd4);
    if (acc_q.size() >= n0 + 4) begin
      for (int i = 1; i < 4; i++)
        check_val("b2b_spacing", 32'(acc_q[n0+i] - acc_q[n0+i-1]), 32'd3);
    end
    $display("txn %0d back-to-back reads accepted=%0d", txn_id, acc_cnt - acc0);
    txn_id++;

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1: begin
          int r;
          r = $urandom_range(0, 15);
          addr = BASE + ((r < 2) ? 32'(r) : 32'(18 + r - 2));
        end
        2:       addr = BASE + 32'($urandom_range(2, 17));
        3:       addr = BASE + 32'd32 + 32'($urandom_range(0, 32'h59F));
        4:       addr = 32'($urandom_range(0, 32'hFFFFFA3F));
        default: addr = $urandom;
      endcase
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      frc   = we && ($urandom_range(0, 1) == 1);
      run_txn(we, addr, wdata, hold, frc);
    end

    for (int i = 0; i < 32; i++) check_val("rf_final", rf[i], shadow[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/lwmac_cfg_master.md
# lwmac_cfg_master

Initiator for the lwmac 32-entry configuration register file. It accepts host read and write requests over a valid/ready channel and checks each absolute address against the 0xFFFFFA40–0xFFFFFA5F window. It drives the register file's write port (write/wrAddr/wrData) and read port (rdAddrA/rdDataA), then returns one response per request. It sits between the host/CPU bus and the register file.

## Interface
- BASE_ADDR, 32'hFFFFFA40, absolute address of register file entry 0
- DATA_W, 32, data width of requests, responses and the register file
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  absolute byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_err  out  1  illegal address, or (with verify) readback mismatch
- rsp_rdata  out  DATA_W  read data, or readback data
- write  out  1  register file write strobe
- wrAddr  out  32  register file write index (offset, zero-extended)
- wrData  out  DATA_W  register file write data
- rdAddrA  out  32  register file read index (offset, zero-extended)
- rdDataA  in  DATA_W  register file read data (combinational from rdAddrA)

## Operation
- Offset = req_addr − BASE_ADDR, computed as 32-bit unsigned. The request is legal only if req_addr lies in [BASE, BASE+0x1F] and the offset is 0x00, 0x01, or 0x12–0x1F. All other offsets are reserved and are errors.
- FSM states:
  - IDLE: req_ready=1. On handshake, latch req_we, offset and wdata. Illegal address → ERR. Legal write → WR. Legal read → RD.
  - WR: write=1 for exactly this cycle, with wrAddr=offset and wrData=wdata. Then → RESP (or VRD when verify is compiled in). rsp_err=0, rsp_rdata=0.
  - RD: rdAddrA=offset (registered at accept). Capture rdDataA into rsp_rdata at the end of the cycle. rsp_err=0. → RESP.
  - ERR: no write strobe; rdAddrA unchanged. rsp_err=1, rsp_rdata=0. → RESP.
  - RESP: rsp_valid=1. Outputs stay stable until rsp_ready. On handshake → IDLE.
- Only one transaction is outstanding. req_ready=0 in every state except IDLE.
- write is never asserted outside WR, and never for an illegal address.

## Timing
- Reset values: req_ready=0 during reset and 1 in the first cycle after it. rsp_valid=0, rsp_err=0, rsp_rdata=0, write=0, wrAddr=0, wrData=0, rdAddrA=0. State = IDLE.
- Request accepted at edge N:
  - Legal write: write is high in cycle N+1; rsp_valid rises in cycle N+2.
  - Legal read: rdDataA is sampled at the end of N+1; rsp_valid rises in N+2.
  - Illegal address: rsp_valid rises in N+2.
- Back-to-back throughput, with rsp_ready held high: one transaction per 3 cycles.
- rsp_valid held with rsp_ready=0: all response outputs stay frozen and req_ready stays 0.
- Reset asserted mid-transaction: the transaction is aborted, write drops on the next edge, no response is produced, and there is no replay.
- Address wrap: req_addr < BASE gives a large unsigned offset. It must be flagged illegal, not aliased.

## Configuration
- CFG_WRITE_VERIFY_EN defined:
  - WR → VRD. VRD drives rdAddrA=offset.
  - → VCMP. VCMP captures rdDataA into rsp_rdata and sets rsp_err = (rdDataA != wdata).
  - → RESP. Write latency becomes N+4 for rsp_valid.
- CFG_WRITE_VERIFY_EN undefined: VRD and VCMP do not exist, and write responses return rsp_rdata=0 with rsp_err=0.
- Read and error paths are identical in both builds.

## Structure
- Package lwmac_cfg_pkg holds:
  - LWMAC_CFG_BASE = 32'hFFFFFA40 and LWMAC_CFG_WORDS = 32
  - legal-offset constants (0x00, 0x01, 0x12–0x1F)
  - the FSM state enum
- Sub-module lwmac_cfg_addr_chk: combinational; takes req_addr, returns legal and offset[4:0]. It is shared with the host bus decoder.

## Test plan
- Write 0xDEADBEEF to 0xFFFFFA52 → write high for one cycle with wrAddr=0x12 and wrData=0xDEADBEEF; rsp_valid two cycles after accept, rsp_err=0.
- Read 0xFFFFFA41 with the register file model holding 0x12345678 at index 1 → rdAddrA=1; rsp_rdata=0x12345678, rsp_err=0.
- Addresses 0xFFFFFA45, 0xFFFFFA60 and 0x00000000 → no write strobe; rsp_err=1, rsp_rdata=0 for each.
- Hold rsp_ready=0 for 5 cycles after a read response → rsp_valid and rsp_rdata stable, req_ready=0; a new req_valid is not accepted.
- Deassert rst_n in the WR cycle of a write to 0xFFFFFA5F → no response, all outputs 0 next cycle, req_ready=1 the cycle after reset releases.
- With CFG_WRITE_VERIFY_EN, write 0xA5A5A5A5 to 0xFFFFFA40 while the model forces readback 0x00000000 → rsp_err=1, rsp_rdata=0; a matching readback → rsp_err=0, rsp_rdata=0xA5A5A5A5.
